uart_tx_engine: RTL and testbench

//  Serial-side responder for the CPU's UART transmit interface. The MEM-stage peripheral

---
 rtl/uart_tx_engine_if.sv | 8 +
 rtl/uart_tx_engine.sv | 62 ++++++
 tb/tb_uart_tx_engine.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_engine_if.sv
// uart_tx_engine_if: byte handshake between the CPU peripheral block and the UART transmitter.
interface uart_tx_engine_if;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    modport master(output tx_data, tx_en, input tx_status);
    modport slave(input tx_data, tx_en, output tx_status);
endinterface

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: one-entry holding register feeding an 8N1/8N2 serial shifter.
module uart_tx_engine #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_engine_if.slave   bus,
    output logic              uart_tx,
    output logic              tx_busy,
    output logic              tx_overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] idx;
    logic [7:0] shifter, hold;
    logic hold_valid, tx_nx, bit_end, stop_done, load, accept;
    assign bit_end = cnt == LAST;
    assign stop_done = state == STOP && bit_end && idx == 3'(STOP_BITS - 1);
    assign load = hold_valid && (state == IDLE || stop_done);
    assign accept = bus.tx_en && !hold_valid;
    assign bus.tx_status = !hold_valid;
    assign tx_busy = state != IDLE;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (hold_valid) state_nx = START;
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && idx == 3'd7) state_nx = STOP;
            STOP:    if (stop_done) state_nx = hold_valid ? START : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_comb tx_nx = state == START ? 1'b0 : state == DATA ? shifter[0] : 1'b1;
    // idx counts data bits, wraps to 0 entering STOP, then counts stop bits
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            uart_tx    <= 1'b1;
            cnt        <= '0;
            idx        <= '0;
            shifter    <= '0;
            hold       <= '0;
            hold_valid <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            uart_tx <= tx_nx;
            cnt     <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            idx     <= (state == IDLE || state == START) ? 3'd0 : bit_end ? idx + 3'd1 : idx;
            shifter <= load ? hold : (state == DATA && bit_end) ? shifter >> 1 : shifter;
            if (accept) begin
                hold       <= bus.tx_data;
                hold_valid <= 1'b1;
            end else if (load) hold_valid <= 1'b0;
            if (bus.tx_en && hold_valid) tx_overrun <= 1'b1;
        end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed and random writes into 8N1 and 8N2 instances, checked per cycle
// against a waveform-level model of the serial line and the holding register.
module tb_uart_tx_engine;
    localparam int CPB = 4;
    logic clk, rst_n, en;
    logic [7:0] din;
    logic line1, busy1, ovr1, line2, busy2, ovr2;
    int checks = 0, errors = 0;
    uart_tx_engine_if b1();
    uart_tx_engine_if b2();
    assign b1.tx_en = en;
    assign b1.tx_data = din;
    assign b2.tx_en = en;
    assign b2.tx_data = din;
    uart_tx_engine #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) d1 (
        .clk(clk), .reset(rst_n), .bus(b1), .uart_tx(line1), .tx_busy(busy1), .tx_overrun(ovr1));
    uart_tx_engine #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) d2 (
        .clk(clk), .reset(rst_n), .bus(b2), .uart_tx(line2), .tx_busy(busy2), .tx_overrun(ovr2));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // model: wv holds the future line values of the frame in flight, LSB = next cycle
    logic [63:0] wv [2];
    int wl [2];
    logic hv [2], ov [2], ln [2];
    logic [7:0] hb [2];
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [63:0] frame(input logic [7:0] b, input int sb);
        logic [63:0] f = '1;
        for (int j = 0; j < (9 + sb) * CPB; j++)
            f[j] = j < CPB ? 1'b0 : j < 9 * CPB ? b[(j - CPB) / CPB] : 1'b1;
        return f;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            wv[i] = '0; wl[i] = 0; hv[i] = 0; ov[i] = 0; ln[i] = 1; hb[i] = '0;
        end
    endtask
    task automatic model_edge(input int i);
        logic acc;
        acc = en && !hv[i];
        if (en && hv[i]) ov[i] = 1;
        if (wl[i] > 0) begin
            ln[i] = wv[i][0];
            wv[i] = wv[i] >> 1;
            wl[i]--;
        end else ln[i] = 1;
        if (hv[i] && wl[i] == 0) begin
            wv[i] = frame(hb[i], i + 1);
            wl[i] = (10 + i) * CPB;
            hv[i] = 0;
        end
        if (acc) begin
            hb[i] = din;
            hv[i] = 1;
        end
    endtask
    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check("line1", 8'(line1), 8'(ln[0]));
        check("status1", 8'(b1.tx_status), 8'(!hv[0]));
        check("busy1", 8'(busy1), 8'(wl[0] > 0));
        check("ovr1", 8'(ovr1), 8'(ov[0]));
        check("line2", 8'(line2), 8'(ln[1]));
        check("status2", 8'(b2.tx_status), 8'(!hv[1]));
        check("busy2", 8'(busy2), 8'(wl[1] > 0));
        check("ovr2", 8'(ovr2), 8'(ov[1]));
    endtask
    task automatic wr(input logic [7:0] b);
        en = 1'b1;
        din = b;
        step();
        en = 1'b0;
    endtask
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask
    task automatic wait_status();
        int n = 0;
        while (!b1.tx_status && n < 200) begin
            step();
            n++;
        end
        check("status_wait", 8'(n < 200), 8'd1);
    endtask
    initial begin
        rst_n = 1'b0; en = 1'b0; din = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_line", 8'(line1), 8'd1);
        check("rst_status", 8'(b1.tx_status), 8'd1);
        check("rst_busy", 8'(busy1), 8'd0);
        @(negedge clk) rst_n = 1'b1;
        idle(100);
        wr(8'hA5);
        idle(60);
        wr(8'h55);
        wait_status();
        wr(8'h0F);
        idle(120);
        wr(8'h01);
        wait_status();
        wr(8'h02);
        wr(8'h03);
        check("ovr_t4", 8'(ovr1), 8'd1);
        idle(150);
        wr(8'h00);
        idle(18);
        check("pre_rst_line", 8'(line1), 8'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_line1", 8'(line1), 8'd1);
        check("arst_line2", 8'(line2), 8'd1);
        check("arst_busy", 8'(busy1), 8'd0);
        check("arst_ovr", 8'(ovr1), 8'd0);
        check("arst_status", 8'(b1.tx_status), 8'd1);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        wr(8'h3C);
        idle(60);
        wr(8'hFF);
        wait_status();
        wr(8'h00);
        idle(120);
        for (int k = 0; k < 1500; k++) begin
            en = $urandom_range(0, 7) == 0;
            din = 8'($urandom);
            step();
        end
        en = 1'b0;
        idle(120);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
